// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small holding FIFO, runtime baud divisor and configurable framing.
// Defining UART_TX_PARITY_EN inserts a parity bit (sense set by PAR_ODD) after the data bits.
module uart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int DIV_W      = 16,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int PAR_ODD    = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIV_W-1:0]              div,
  input  logic                          vld_tx,
  input  logic [DATA_W-1:0]             d_tx,
  output logic                          rdy_tx,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int IDX_W = $clog2(DATA_W);

  generate
    if (DATA_W < 5 || DATA_W > 9 || (STOP_BITS != 1 && STOP_BITS != 2) ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        PAR_ODD < 0 || PAR_ODD > 1) begin : g_bad_params
      $error("uart_tx_fifo: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  // ---------------------------------------------------------------
  // Holding FIFO
  // ---------------------------------------------------------------
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [DATA_W-1:0] head_data;
  logic              push;
  logic              pop;
  logic              fifo_nonempty;

  assign rdy_tx        = (cnt_reg != CNT_W'(FIFO_DEPTH));
  assign push          = vld_tx && rdy_tx;
  assign fifo_nonempty = (cnt_reg != '0);
  assign head_data     = mem[rd_ptr_reg];
  assign fifo_cnt      = cnt_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= d_tx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   cnt_reg <= cnt_reg + CNT_W'(1);
        2'b01:   cnt_reg <= cnt_reg - CNT_W'(1);
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end

  // ---------------------------------------------------------------
  // Frame sequencer
  // ---------------------------------------------------------------
  state_t            state_reg;
  logic [DIV_W-1:0]  div_q_reg;
  logic [DIV_W-1:0]  baud_reg;
  logic [DATA_W-1:0] shift_reg;
  logic [IDX_W-1:0]  bit_idx_reg;
  logic              stop_idx_reg;
  logic              txd_reg;
  logic              busy_reg;
  logic              bit_end;
  logic              stop_last;
`ifdef UART_TX_PARITY_EN
  logic              par_reg;
`endif

  assign bit_end   = (baud_reg == '0);
  assign stop_last = (stop_idx_reg == 1'(STOP_BITS - 1));

  // A new frame starts from IDLE, or straight out of the final stop bit so frames abut.
  assign pop = fifo_nonempty &&
               ((state_reg == S_IDLE) || (state_reg == S_STOP && bit_end && stop_last));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      div_q_reg    <= '0;
      baud_reg     <= '0;
      shift_reg    <= '0;
      bit_idx_reg  <= '0;
      stop_idx_reg <= 1'b0;
      txd_reg      <= 1'b1;
      busy_reg     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_reg      <= 1'b0;
`endif
    end else if (pop) begin
      shift_reg    <= head_data;
      div_q_reg    <= div;
      baud_reg     <= div;
      bit_idx_reg  <= '0;
      stop_idx_reg <= 1'b0;
      txd_reg      <= 1'b0;
      busy_reg     <= 1'b1;
      state_reg    <= S_START;
`ifdef UART_TX_PARITY_EN
      // Parity taken from the word as popped; the shift register is consumed later.
      par_reg      <= (^head_data) ^ 1'(PAR_ODD);
`endif
    end else begin
      case (state_reg)
        S_IDLE: begin
          txd_reg  <= 1'b1;
          busy_reg <= 1'b0;
        end

        S_START: begin
          if (bit_end) begin
            baud_reg    <= div_q_reg;
            txd_reg     <= shift_reg[0];
            shift_reg   <= shift_reg >> 1;
            bit_idx_reg <= '0;
            state_reg   <= S_DATA;
          end else begin
            baud_reg <= baud_reg - DIV_W'(1);
          end
        end

        S_DATA: begin
          if (bit_end) begin
            baud_reg <= div_q_reg;
            if (bit_idx_reg == IDX_W'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
              txd_reg   <= par_reg;
              state_reg <= S_PARITY;
`else
              txd_reg      <= 1'b1;
              stop_idx_reg <= 1'b0;
              state_reg    <= S_STOP;
`endif
            end else begin
              txd_reg     <= shift_reg[0];
              shift_reg   <= shift_reg >> 1;
              bit_idx_reg <= bit_idx_reg + IDX_W'(1);
            end
          end else begin
            baud_reg <= baud_reg - DIV_W'(1);
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            baud_reg     <= div_q_reg;
            txd_reg      <= 1'b1;
            stop_idx_reg <= 1'b0;
            state_reg    <= S_STOP;
          end else begin
            baud_reg <= baud_reg - DIV_W'(1);
          end
        end
`endif

        S_STOP: begin
          if (bit_end) begin
            baud_reg <= div_q_reg;
            if (stop_last) begin
              txd_reg   <= 1'b1;
              busy_reg  <= 1'b0;
              state_reg <= S_IDLE;
            end else begin
              stop_idx_reg <= stop_idx_reg + 1'b1;
            end
          end else begin
            baud_reg <= baud_reg - DIV_W'(1);
          end
        end

        default: begin
          txd_reg   <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign txd  = txd_reg;
  assign busy = busy_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: reset, single frame, FIFO fill/drop, push-with-pop, divisor handling.
// Compiling with UART_TX_PARITY_EN adds the parity bit to every expected frame plus a parity-focused case.
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] div = 16'd3;
  logic        vld_tx = 1'b0;
  logic [7:0]  d_tx = 8'h00;
  logic        rdy_tx;
  logic        txd;
  logic        busy;
  logic [2:0]  fifo_cnt;

  int n_cmp = 0;
  int n_err = 0;

  uart_tx_fifo #(
    .DATA_W(8), .DIV_W(16), .STOP_BITS(1), .FIFO_DEPTH(4), .PAR_ODD(0)
  ) dut (
    .clk(clk), .rst(rst), .div(div), .vld_tx(vld_tx), .d_tx(d_tx),
    .rdy_tx(rdy_tx), .txd(txd), .busy(busy), .fifo_cnt(fifo_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called on the negedge where the start bit is first visible; returns one
  // negedge after the final stop cycle.
  task automatic expect_frame(input logic [7:0] data, input int divv, input string tag);
    logic seq [0:11];
    int nb;
    seq[0] = 1'b0;
    for (int i = 0; i < 8; i++) seq[i+1] = data[i];
    nb = 9;
`ifdef UART_TX_PARITY_EN
    seq[nb] = ^data;
    nb++;
`endif
    seq[nb] = 1'b1;
    nb++;
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k <= divv; k++) begin
        check($sformatf("%s txd bit%0d cyc%0d", tag, b, k), 32'(txd), 32'(seq[b]));
        check($sformatf("%s busy bit%0d", tag, b), 32'(busy), 32'd1);
        @(negedge clk);
      end
    end
    $display("tx frame %s data=%02h div=%0d bits=%0d", tag, data, divv, nb);
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    check("rst txd", 32'(txd), 32'd1);
    check("rst rdy_tx", 32'(rdy_tx), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    check("rst fifo_cnt", 32'(fifo_cnt), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single word 0x55, div=3: latency and 40-cycle frame
    div = 16'd3;
    vld_tx = 1'b1; d_tx = 8'h55;
    @(negedge clk);
    vld_tx = 1'b0;
    check("lat cnt after push", 32'(fifo_cnt), 32'd1);
    check("lat txd before pop", 32'(txd), 32'd1);
    check("lat busy before pop", 32'(busy), 32'd0);
    @(negedge clk);
    check("lat cnt after pop", 32'(fifo_cnt), 32'd0);
    expect_frame(8'h55, 3, "single");
    check("single idle busy", 32'(busy), 32'd0);
    check("single idle txd", 32'(txd), 32'd1);
    repeat (3) @(negedge clk);

    // Six words into a depth-4 FIFO at div=1; sixth offered while full is dropped
    div = 16'd1;
    fork
      begin
        vld_tx = 1'b1; d_tx = 8'h11;
        @(negedge clk); d_tx = 8'h22;
        @(negedge clk); check("full cnt after E1", 32'(fifo_cnt), 32'd1); d_tx = 8'h33;
        @(negedge clk); d_tx = 8'h44;
        @(negedge clk); d_tx = 8'h55;
        @(negedge clk);
        check("full rdy_tx", 32'(rdy_tx), 32'd0);
        check("full fifo_cnt", 32'(fifo_cnt), 32'd4);
        d_tx = 8'h66;
        @(negedge clk);
        check("drop fifo_cnt", 32'(fifo_cnt), 32'd4);
        vld_tx = 1'b0;
      end
      begin
        repeat (2) @(negedge clk);
        expect_frame(8'h11, 1, "b2b0");
        expect_frame(8'h22, 1, "b2b1");
        expect_frame(8'h33, 1, "b2b2");
        expect_frame(8'h44, 1, "b2b3");
        expect_frame(8'h55, 1, "b2b4");
        check("b2b end busy", 32'(busy), 32'd0);
        check("b2b end cnt", 32'(fifo_cnt), 32'd0);
      end
    join
    repeat (3) @(negedge clk);

    // Push coinciding with the STOP->START pop while three words are held
    fork
      begin
        vld_tx = 1'b1; d_tx = 8'hA1;
        @(negedge clk); d_tx = 8'hB2;
        @(negedge clk); d_tx = 8'hC3;
        @(negedge clk); d_tx = 8'hD4;
        @(negedge clk); vld_tx = 1'b0;
        check("pp cnt before", 32'(fifo_cnt), 32'd3);
        repeat (17) @(negedge clk);
        check("pp cnt pre-edge", 32'(fifo_cnt), 32'd3);
        vld_tx = 1'b1; d_tx = 8'hE5;
        @(negedge clk);
        vld_tx = 1'b0;
        check("pp cnt after push+pop", 32'(fifo_cnt), 32'd3);
      end
      begin
        repeat (2) @(negedge clk);
        expect_frame(8'hA1, 1, "pp0");
        expect_frame(8'hB2, 1, "pp1");
        expect_frame(8'hC3, 1, "pp2");
        expect_frame(8'hD4, 1, "pp3");
        expect_frame(8'hE5, 1, "pp4");
        check("pp end busy", 32'(busy), 32'd0);
      end
    join
    repeat (3) @(negedge clk);

    // div=0 frame, then div changed mid-frame affects only the next frame
    div = 16'd0;
    fork
      begin
        vld_tx = 1'b1; d_tx = 8'hA3;
        @(negedge clk); d_tx = 8'h3C;
        @(negedge clk); vld_tx = 1'b0;
        repeat (3) @(negedge clk);
        div = 16'd7;
      end
      begin
        repeat (2) @(negedge clk);
        expect_frame(8'hA3, 0, "div0");
        expect_frame(8'h3C, 7, "div7");
        check("div end busy", 32'(busy), 32'd0);
      end
    join
    repeat (3) @(negedge clk);

`ifdef UART_TX_PARITY_EN
    // 0x07 has three ones: even-sense parity bit is 1
    div = 16'd2;
    vld_tx = 1'b1; d_tx = 8'h07;
    @(negedge clk); vld_tx = 1'b0;
    @(negedge clk);
    expect_frame(8'h07, 2, "par07");
    check("par end busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
`endif

    // Reset asserted mid-frame acts immediately
    div = 16'd3;
    vld_tx = 1'b1; d_tx = 8'h00;
    @(negedge clk); d_tx = 8'h0F;
    @(negedge clk); vld_tx = 1'b0;
    repeat (6) @(negedge clk);
    check("mid txd low", 32'(txd), 32'd0);
    check("mid busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async rst txd", 32'(txd), 32'd1);
    check("async rst rdy_tx", 32'(rdy_tx), 32'd1);
    check("async rst busy", 32'(busy), 32'd0);
    check("async rst fifo_cnt", 32'(fifo_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("post rst txd cyc%0d", i), 32'(txd), 32'd1);
      check($sformatf("post rst busy cyc%0d", i), 32'(busy), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Parametrised UART transmit engine for the serial debug path; successor to the single-flag transmit-ready logic.
- Integrates baud divider, valid/ready input handshake, FIFO_DEPTH-entry holding FIFO, configurable data/stop bits and optional parity.
- Sits between the debug command/response logic (producer) and the board TXD pin.

Parameters:
- DATA_W, 8, data bits per frame (5..9), sent LSB first.
- DIV_W, 16, width of baud divisor input.
- STOP_BITS, 1, stop bits per frame (1 or 2).
- FIFO_DEPTH, 4, holding FIFO entries (power of 2, >=2).
- PAR_ODD, 0, parity sense when UART_TX_PARITY_EN is defined (0 = even, 1 = odd); ignored otherwise.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- div  in  DIV_W  baud divisor; bit period = div+1 clk cycles.
- vld_tx  in  1  producer has a word on d_tx.
- d_tx  in  DATA_W  word to transmit.
- rdy_tx  out  1  FIFO not full; word accepted on the edge where vld_tx && rdy_tx.
- txd  out  1  serial line, idle high.
- busy  out  1  frame in progress (FSM not IDLE).
- fifo_cnt  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, immediate): txd=1, rdy_tx=1, busy=0, fifo_cnt=0, FSM=IDLE, baud counter=0, FIFO contents discarded. Reset mid-frame aborts the frame; txd returns high at once.
- rdy_tx = (fifo_cnt != FIFO_DEPTH), derived from registered count only, never from vld_tx.
- Push: vld_tx && rdy_tx writes d_tx at tail. vld_tx while full is ignored, word dropped, no state change.
- Pop: FSM pops the head when it leaves IDLE or STOP toward START. Simultaneous push and pop leaves fifo_cnt unchanged, including at count = FIFO_DEPTH-1 and count = 1.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
- IDLE: txd=1. If fifo_cnt != 0: pop head into shift register, latch div into div_q, load baud counter with div_q, go START.
- Each bit lasts div_q+1 cycles. The baud counter counts down to 0; the bit ends on the cycle the counter is 0, then reloads div_q.
- START: txd=0 for one bit, then DATA with bit index 0.
- DATA: txd = shift[0]; shift right and increment the index at bit end. After DATA_W bits go PARITY (macro) or STOP.
- STOP: txd=1 for STOP_BITS bit periods. At the end, if fifo_cnt != 0, pop and go START directly (back-to-back, no idle cycle, div re-latched); else go IDLE.
- Latency: word pushed into an empty FIFO with FSM idle at edge N; the pop occurs at edge N+1 and txd=0 is visible after edge N+1.
- busy=1 in every state except IDLE.
- div changes mid-frame have no effect until the next frame start. div=0 gives a 1-cycle bit period and is legal.
- Frame length in cycles = (div+1) * (1 + DATA_W + P + STOP_BITS), where P=1 with parity, else 0.
- txd is driven from a register (glitch-free).

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: PARITY state inserted after DATA, one bit period long.
  - txd = ^data XOR PAR_ODD.
  - Parity is computed from the word as popped, not from the shifted register.
- Undefined: no PARITY state, no parity logic; PAR_ODD unused; DATA goes directly to STOP.

Test Plan:
- Reset: assert rst mid-frame -> txd=1, rdy_tx=1, busy=0, fifo_cnt=0 immediately (asynchronously). After release, txd stays 1 with no vld_tx.
- Single word: DATA_W=8, STOP_BITS=1, div=3, push 0x55 -> txd low after edge N+1, then 4-cycle bits 1,0,1,0,1,0,1,0 (LSB first), then stop 1. busy high for 40 cycles, then IDLE.
- Back-to-back/full: FIFO_DEPTH=4, div=1, push 6 words consecutively -> first is popped at once; 4 more fill FIFO; rdy_tx=0 with fifo_cnt=4 while the 6th is offered. 6th dropped unless held until rdy_tx=1. Frames on txd are contiguous: stop bit immediately followed by start bit.
- Simultaneous push/pop at full-1: fifo_cnt=3, push on the same edge as a STOP->START pop -> fifo_cnt stays 3, data order preserved.
- div=0 and div change: div=0, push 0xA3 -> 10-cycle frame. Change div to 7 mid-frame -> current frame unchanged; next frame uses 8-cycle bits.
- Parity (macro defined, PAR_ODD=0): push 0x07 -> parity bit 1. PAR_ODD=1 -> 0. Frame = 11 bit periods. STOP_BITS=2 -> 12 bit periods.
